config_chain_loader: RTL and testbench

Streams a configuration bitstream into the FPGA fabric's configuration flip-flop chain, the ccff_head → ccff_tail chain that runs through every connection block, switch block and grid memory. It is the only master of that chain and is clocked by prog_clk. It accepts bitstream words over a valid/ready handshake and serialises them LSB-first onto ccff_head. It drives the chain shift enable so that the chain only advances on real data bits. An optional verify pass re-streams the same bitstream and compares it bit by bit against what emerges at ccff_tail.

---
 rtl/config_chain_loader.sv | 156 +++++++++++++++
 tb/tb_config_chain_loader.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/config_chain_loader.sv
// config_chain_loader
// Sole master of the ccff_head -> ccff_tail configuration chain. Accepts
// bitstream words over valid/ready, shifts them LSB-first into the chain and
// advances the chain only on real data bits. A verify pass re-streams the
// bitstream and compares each bit against the one leaving ccff_tail.
module config_chain_loader #(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              prog_rst_n,
  input  logic              start,
  input  logic              verify,
  input  logic              abort,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              verify_err,
  output logic [7:0]        err_count
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int WB_W  = $clog2(WORD_W + 1);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [WB_W-1:0]  WB_FULL  = WB_W'(WORD_W);
  localparam logic [WB_W-1:0]  WB_ONE   = WB_W'(1);
  localparam logic [7:0]       ERR_MAX  = 8'd255;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIN
  } state_t;

  state_t             state_q, state_d;
  logic [WORD_W-1:0]  sreg_q, sreg_d;
  logic [WB_W-1:0]    wbits_q, wbits_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mode_q, mode_d;
  logic               done_q, done_d;
  logic               verify_err_q, verify_err_d;
  logic [7:0]         err_count_q, err_count_d;

  logic in_run;
  logic word_live;
  logic shift_fire;
  logic mismatch;

  // Decode handshake and chain-facing strobes from the registered state and abort
  always_comb begin
    in_run        = (state_q == ST_RUN);
    word_live     = (wbits_q != '0);
    shift_fire    = in_run && word_live && !abort;
    mismatch      = mode_q && shift_fire && (ccff_tail != sreg_q[0]);
    s_ready       = in_run && !word_live && !abort && (cnt_q != '0);
    ccff_head     = (in_run && word_live) ? sreg_q[0] : 1'b0;
    ccff_shift_en = shift_fire;
    busy          = in_run;
    done          = done_q;
    verify_err    = verify_err_q;
    err_count     = err_count_q;
  end

  // Next-state logic: pass sequencing, word intake, shifting and verify compare
  always_comb begin
    state_d      = state_q;
    sreg_d       = sreg_q;
    wbits_d      = wbits_q;
    cnt_d        = cnt_q;
    mode_d       = mode_q;
    done_d       = done_q;
    verify_err_d = verify_err_q;
    err_count_d  = err_count_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_RUN;
          cnt_d        = CNT_FULL;
          wbits_d      = '0;
          sreg_d       = '0;
          mode_d       = verify;
          done_d       = 1'b0;
          verify_err_d = 1'b0;
          err_count_d  = '0;
        end
      end

      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
          wbits_d = '0;
          sreg_d  = '0;
          done_d  = 1'b0;
        end else if (word_live) begin
          sreg_d  = sreg_q >> 1;
          wbits_d = wbits_q - WB_ONE;
          cnt_d   = cnt_q - CNT_ONE;
          if (mismatch) begin
            verify_err_d = 1'b1;
            if (err_count_q != ERR_MAX) begin
              err_count_d = err_count_q + 8'd1;
            end
          end
          if (cnt_q == CNT_ONE) begin
            wbits_d = '0;
            state_d = ST_FIN;
            done_d  = 1'b1;
          end
        end else if (s_valid && (cnt_q != '0)) begin
          sreg_d  = s_data;
          wbits_d = WB_FULL;
        end
      end

      ST_FIN: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; asynchronous reset returns every output to zero
  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      state_q      <= ST_IDLE;
      sreg_q       <= '0;
      wbits_q      <= '0;
      cnt_q        <= '0;
      mode_q       <= 1'b0;
      done_q       <= 1'b0;
      verify_err_q <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      sreg_q       <= sreg_d;
      wbits_q      <= wbits_d;
      cnt_q        <= cnt_d;
      mode_q       <= mode_d;
      done_q       <= done_d;
      verify_err_q <= verify_err_d;
      err_count_q  <= err_count_d;
    end
  end

endmodule

// File: tb/tb_config_chain_loader.sv
// Testbench for config_chain_loader: a 10-bit chain instance driven through
// load, stall, verify, abort and reset scenarios against a shift-register
// chain model, plus a 300-bit instance whose tail always disagrees.
module tb_config_chain_loader;

  localparam int CL     = 10;
  localparam int WW     = 4;
  localparam int CL_SAT = 300;

  logic          prog_clk   = 1'b0;
  logic          prog_rst_n = 1'b0;
  logic          start      = 1'b0;
  logic          verify     = 1'b0;
  logic          abort      = 1'b0;
  logic          s_valid    = 1'b0;
  logic [WW-1:0] s_data     = '0;
  logic          s_ready, ccff_head, ccff_shift_en, ccff_tail, busy, done, verify_err;
  logic [7:0]    err_count;

  logic          start2   = 1'b0;
  logic          verify2  = 1'b0;
  logic          abort2   = 1'b0;
  logic          s_valid2 = 1'b0;
  logic [WW-1:0] s_data2  = '0;
  logic          s_ready2, head2, shift_en2, tail2, busy2, done2, verify_err2;
  logic [7:0]    err_count2;

  logic [CL-1:0] chain = '0;

  int checks = 0;
  int errors = 0;

  logic [WW-1:0] words[$];
  bit            exp_q[$];
  logic          obs_q[$];
  bit            cur_bits[$];
  bit            prev_bits[$];
  int            shifts, hs, stall_shifts, last_shift_cyc, done_cyc;
  bit            timed_out;
  logic          ab_en, ab_ready, af_busy, af_done, af_ready, af_en;

  config_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
    .prog_clk(prog_clk), .prog_rst_n(prog_rst_n), .start(start), .verify(verify),
    .abort(abort), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .ccff_head(ccff_head), .ccff_shift_en(ccff_shift_en), .ccff_tail(ccff_tail),
    .busy(busy), .done(done), .verify_err(verify_err), .err_count(err_count)
  );

  config_chain_loader #(.CHAIN_LEN(CL_SAT), .WORD_W(WW)) dut_sat (
    .prog_clk(prog_clk), .prog_rst_n(prog_rst_n), .start(start2), .verify(verify2),
    .abort(abort2), .s_data(s_data2), .s_valid(s_valid2), .s_ready(s_ready2),
    .ccff_head(head2), .ccff_shift_en(shift_en2), .ccff_tail(tail2),
    .busy(busy2), .done(done2), .verify_err(verify_err2), .err_count(err_count2)
  );

  // Free-running configuration clock
  always #5 prog_clk = ~prog_clk;

  // Chain model: a plain FIFO of CL flops advanced only by the shift enable
  always @(posedge prog_clk) begin
    if (ccff_shift_en) chain <= {ccff_head, chain[CL-1:1]};
  end
  assign ccff_tail = chain[0];

  // Saturation chain always returns the opposite of what is being shifted in
  assign tail2 = ~head2;

  // Runs one pass on the 10-bit instance, recording what the chain saw
  task automatic drive_pass(input bit vmode, input int gap, input int abort_at, input int restart_at);
    int idx = 0, gapcnt = 0, left = 0, pushed = 0;
    bit fin = 0, ab_fired = 0, rs_fired = 0, aborted = 0;
    shifts = 0; hs = 0; stall_shifts = 0; last_shift_cyc = -1; done_cyc = -1; timed_out = 0;
    ab_en = 1'bx; ab_ready = 1'bx; af_busy = 1'bx; af_done = 1'bx; af_ready = 1'bx; af_en = 1'bx;
    exp_q.delete(); obs_q.delete();
    @(negedge prog_clk); start = 1'b1; verify = vmode;
    @(negedge prog_clk); start = 1'b0; verify = 1'b0;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      abort = (abort_at >= 0) && (shifts == abort_at) && !ab_fired;
      start = (restart_at >= 0) && (shifts == restart_at) && !rs_fired;
      if (start) rs_fired = 1;
      if (idx < words.size() && gapcnt == 0) begin
        s_valid = 1'b1; s_data = words[idx];
      end else begin
        s_valid = 1'b0; s_data = '0;
      end
      #1;
      if (aborted) begin
        af_busy = busy; af_done = done; af_ready = s_ready; af_en = ccff_shift_en; fin = 1;
      end
      if (ccff_shift_en) begin
        obs_q.push_back(ccff_head);
        shifts++; last_shift_cyc = cyc;
        if (left == 0) stall_shifts++; else left--;
      end else if (gapcnt > 0 && !s_valid && left == 0) begin
        gapcnt--;
      end
      if (s_valid && s_ready) begin
        hs++; idx++; gapcnt = gap; left = WW;
        for (int b = 0; b < WW; b++) begin
          if (pushed < CL) begin exp_q.push_back(s_data[b]); pushed++; end
        end
      end
      if (abort) begin
        ab_en = ccff_shift_en; ab_ready = s_ready; ab_fired = 1; aborted = 1;
      end
      if (done && done_cyc < 0 && !aborted) begin done_cyc = cyc; fin = 1; end
      @(negedge prog_clk);
    end
    if (!fin) timed_out = 1;
    s_valid = 1'b0; abort = 1'b0; start = 1'b0;
    if (done_cyc >= 0) begin prev_bits = cur_bits; cur_bits = exp_q; end
  endtask

  // Outputs held at zero under reset, start ignored while reset is asserted
  task automatic test_reset();
    prog_rst_n = 1'b0; start = 1'b1; verify = 1'b1; start2 = 1'b1;
    repeat (3) @(negedge prog_clk);
    #1;
    checks++; if (s_ready !== 1'b0)       begin errors++; $display("[TB] FAIL rst_s_ready got %b exp 0", s_ready); end
    checks++; if (ccff_head !== 1'b0)     begin errors++; $display("[TB] FAIL rst_head got %b exp 0", ccff_head); end
    checks++; if (ccff_shift_en !== 1'b0) begin errors++; $display("[TB] FAIL rst_shift_en got %b exp 0", ccff_shift_en); end
    checks++; if (busy !== 1'b0)          begin errors++; $display("[TB] FAIL rst_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0)          begin errors++; $display("[TB] FAIL rst_done got %b exp 0", done); end
    checks++; if (verify_err !== 1'b0)    begin errors++; $display("[TB] FAIL rst_verify_err got %b exp 0", verify_err); end
    checks++; if (err_count !== 8'd0)     begin errors++; $display("[TB] FAIL rst_err_count got %0d exp 0", err_count); end
    start = 1'b0; verify = 1'b0; start2 = 1'b0;
    @(negedge prog_clk); prog_rst_n = 1'b1;
    @(negedge prog_clk); #1;
    checks++; if (busy !== 1'b0)  begin errors++; $display("[TB] FAIL rst_release_busy got %b exp 0", busy); end
    checks++; if (busy2 !== 1'b0) begin errors++; $display("[TB] FAIL rst_release_busy2 got %b exp 0", busy2); end
  endtask

  // Plain load pass with s_valid held high
  task automatic test_load();
    logic o; bit e; int k = 0;
    words = '{4'h5, 4'hA, 4'h3};
    drive_pass(1'b0, 0, -1, -1);
    checks++; if (timed_out !== 1'b0) begin errors++; $display("[TB] FAIL load_timeout got %b exp 0", timed_out); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bx;
      checks++; if (o !== e) begin errors++; $display("[TB] FAIL load_bit%0d got %b exp %b", k, o, e); end
      k++;
    end
    checks++; if (shifts != CL) begin errors++; $display("[TB] FAIL load_shifts got %0d exp %0d", shifts, CL); end
    checks++; if (hs != 3) begin errors++; $display("[TB] FAIL load_handshakes got %0d exp 3", hs); end
    checks++; if (done_cyc - last_shift_cyc != 1) begin errors++; $display("[TB] FAIL load_done_lat got %0d exp 1", done_cyc - last_shift_cyc); end
    checks++; if (done_cyc != 3 + CL) begin errors++; $display("[TB] FAIL load_cycles got %0d exp %0d", done_cyc, 3 + CL); end
    checks++; if (stall_shifts != 0) begin errors++; $display("[TB] FAIL load_stray_shift got %0d exp 0", stall_shifts); end
  endtask

  // Same words with 5 idle s_valid cycles between words
  task automatic test_stall();
    logic o; bit e; int k = 0;
    words = '{4'h5, 4'hA, 4'h3};
    drive_pass(1'b0, 5, -1, -1);
    checks++; if (timed_out !== 1'b0) begin errors++; $display("[TB] FAIL stall_timeout got %b exp 0", timed_out); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bx;
      checks++; if (o !== e) begin errors++; $display("[TB] FAIL stall_bit%0d got %b exp %b", k, o, e); end
      k++;
    end
    checks++; if (shifts != CL) begin errors++; $display("[TB] FAIL stall_shifts got %0d exp %0d", shifts, CL); end
    checks++; if (stall_shifts != 0) begin errors++; $display("[TB] FAIL stall_gap_shift got %0d exp 0", stall_shifts); end
    checks++; if (done_cyc != 3 + CL + 2 * 5) begin errors++; $display("[TB] FAIL stall_cycles got %0d exp %0d", done_cyc, 3 + CL + 10); end
  endtask

  // Verify pass with the bitstream already in the chain
  task automatic test_verify_ok();
    int exp_err = 0;
    words = '{4'h5, 4'hA, 4'h3};
    drive_pass(1'b1, 0, -1, -1);
    for (int i = 0; i < CL; i++) if (cur_bits[i] != prev_bits[i]) exp_err++;
    checks++; if (timed_out !== 1'b0) begin errors++; $display("[TB] FAIL vok_timeout got %b exp 0", timed_out); end
    checks++; if (err_count !== 8'(exp_err)) begin errors++; $display("[TB] FAIL vok_err_count got %0d exp %0d", err_count, exp_err); end
    checks++; if (verify_err !== (exp_err != 0)) begin errors++; $display("[TB] FAIL vok_verify_err got %b exp %b", verify_err, exp_err != 0); end
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL vok_done got %b exp 1", done); end
  endtask

  // Verify pass with one word altered
  task automatic test_verify_bad();
    int exp_err = 0;
    words = '{4'h5, 4'hB, 4'h3};
    drive_pass(1'b1, 0, -1, -1);
    for (int i = 0; i < CL; i++) if (cur_bits[i] != prev_bits[i]) exp_err++;
    checks++; if (exp_err != 1) begin errors++; $display("[TB] FAIL vbad_model got %0d exp 1", exp_err); end
    checks++; if (err_count !== 8'(exp_err)) begin errors++; $display("[TB] FAIL vbad_err_count got %0d exp %0d", err_count, exp_err); end
    checks++; if (verify_err !== 1'b1) begin errors++; $display("[TB] FAIL vbad_verify_err got %b exp 1", verify_err); end
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL vbad_done got %b exp 1", done); end
  endtask

  // Abort after 6 shifts, then a full pass
  task automatic test_abort();
    logic o; bit e;
    words = '{4'h5, 4'hA, 4'h3};
    drive_pass(1'b0, 0, 6, -1);
    checks++; if (timed_out !== 1'b0) begin errors++; $display("[TB] FAIL abort_timeout got %b exp 0", timed_out); end
    checks++; if (shifts != 6) begin errors++; $display("[TB] FAIL abort_shifts got %0d exp 6", shifts); end
    checks++; if (ab_en !== 1'b0) begin errors++; $display("[TB] FAIL abort_cycle_shift got %b exp 0", ab_en); end
    checks++; if (ab_ready !== 1'b0) begin errors++; $display("[TB] FAIL abort_cycle_ready got %b exp 0", ab_ready); end
    checks++; if (af_busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_next_busy got %b exp 0", af_busy); end
    checks++; if (af_done !== 1'b0) begin errors++; $display("[TB] FAIL abort_next_done got %b exp 0", af_done); end
    checks++; if (af_ready !== 1'b0) begin errors++; $display("[TB] FAIL abort_next_ready got %b exp 0", af_ready); end
    checks++; if (af_en !== 1'b0) begin errors++; $display("[TB] FAIL abort_next_shift got %b exp 0", af_en); end
    for (int k = 0; k < 6; k++) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bx;
      checks++; if (o !== e) begin errors++; $display("[TB] FAIL abort_bit%0d got %b exp %b", k, o, e); end
    end
    drive_pass(1'b0, 0, -1, -1);
    checks++; if (shifts != CL) begin errors++; $display("[TB] FAIL abort_rerun_shifts got %0d exp %0d", shifts, CL); end
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL abort_rerun_done got %b exp 1", done); end
  endtask

  // A start pulse in the middle of a pass must not restart it
  task automatic test_start_while_busy();
    logic o; bit e; int k = 0;
    words = '{4'h5, 4'hA, 4'h3};
    drive_pass(1'b0, 0, -1, 3);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bx;
      checks++; if (o !== e) begin errors++; $display("[TB] FAIL busy_start_bit%0d got %b exp %b", k, o, e); end
      k++;
    end
    checks++; if (shifts != CL) begin errors++; $display("[TB] FAIL busy_start_shifts got %0d exp %0d", shifts, CL); end
    checks++; if (hs != 3) begin errors++; $display("[TB] FAIL busy_start_handshakes got %0d exp 3", hs); end
    checks++; if (done_cyc - last_shift_cyc != 1) begin errors++; $display("[TB] FAIL busy_start_done_lat got %0d exp 1", done_cyc - last_shift_cyc); end
  endtask

  // Reset asserted during a verify pass that has already seen a mismatch
  task automatic test_reset_mid_pass();
    int n = 0, idx = 0, exp_err = 0;
    logic [WW-1:0] w;
    words = '{4'h5, 4'hB, 4'h3};
    for (int k = 0; k < 6; k++) begin
      w = words[k / WW];
      if (w[k % WW] != cur_bits[k]) exp_err++;
    end
    @(negedge prog_clk); start = 1'b1; verify = 1'b1;
    @(negedge prog_clk); start = 1'b0; verify = 1'b0;
    for (int c = 0; c < 40 && n < 6; c++) begin
      s_valid = 1'b1; s_data = words[idx];
      #1;
      if (ccff_shift_en) n++;
      if (s_valid && s_ready) idx++;
      @(negedge prog_clk);
    end
    s_valid = 1'b0;
    #1;
    checks++; if (n != 6) begin errors++; $display("[TB] FAIL rmid_reach got %0d exp 6", n); end
    checks++; if (err_count !== 8'(exp_err)) begin errors++; $display("[TB] FAIL rmid_pre_err got %0d exp %0d", err_count, exp_err); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL rmid_pre_busy got %b exp 1", busy); end
    prog_rst_n = 1'b0; start = 1'b1;
    #1;
    checks++; if (s_ready !== 1'b0)       begin errors++; $display("[TB] FAIL rmid_s_ready got %b exp 0", s_ready); end
    checks++; if (ccff_head !== 1'b0)     begin errors++; $display("[TB] FAIL rmid_head got %b exp 0", ccff_head); end
    checks++; if (ccff_shift_en !== 1'b0) begin errors++; $display("[TB] FAIL rmid_shift_en got %b exp 0", ccff_shift_en); end
    checks++; if (busy !== 1'b0)          begin errors++; $display("[TB] FAIL rmid_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0)          begin errors++; $display("[TB] FAIL rmid_done got %b exp 0", done); end
    checks++; if (verify_err !== 1'b0)    begin errors++; $display("[TB] FAIL rmid_verify_err got %b exp 0", verify_err); end
    checks++; if (err_count !== 8'd0)     begin errors++; $display("[TB] FAIL rmid_err_count got %0d exp 0", err_count); end
    @(negedge prog_clk); start = 1'b0; prog_rst_n = 1'b1;
    @(negedge prog_clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rmid_after_busy got %b exp 0", busy); end
  endtask

  // 300 forced mismatches must saturate err_count at 255
  task automatic test_saturation();
    int n = 0, exp_cnt;
    bit fin = 0;
    @(negedge prog_clk); start2 = 1'b1; verify2 = 1'b1;
    @(negedge prog_clk); start2 = 1'b0; verify2 = 1'b0;
    for (int c = 0; c < 2000 && !fin; c++) begin
      s_valid2 = 1'b1; s_data2 = WW'($urandom);
      #1;
      if (shift_en2) n++;
      if (done2) fin = 1;
      @(negedge prog_clk);
    end
    s_valid2 = 1'b0;
    #1;
    exp_cnt = (n > 255) ? 255 : n;
    checks++; if (fin !== 1'b1) begin errors++; $display("[TB] FAIL sat_timeout got %b exp 1", fin); end
    checks++; if (n != CL_SAT) begin errors++; $display("[TB] FAIL sat_shifts got %0d exp %0d", n, CL_SAT); end
    checks++; if (err_count2 !== 8'(exp_cnt)) begin errors++; $display("[TB] FAIL sat_err_count got %0d exp %0d", err_count2, exp_cnt); end
    checks++; if (verify_err2 !== 1'b1) begin errors++; $display("[TB] FAIL sat_verify_err got %b exp 1", verify_err2); end
    checks++; if (done2 !== 1'b1) begin errors++; $display("[TB] FAIL sat_done got %b exp 1", done2); end
    @(negedge prog_clk); start2 = 1'b1; verify2 = 1'b1;
    @(negedge prog_clk); start2 = 1'b0; verify2 = 1'b0;
    n = 0;
    for (int c = 0; c < 100 && n < 20; c++) begin
      s_valid2 = 1'b1; s_data2 = WW'($urandom);
      #1;
      if (shift_en2) n++;
      @(negedge prog_clk);
    end
    s_valid2 = 1'b0;
    #1;
    checks++; if (err_count2 !== 8'(n)) begin errors++; $display("[TB] FAIL sat_restart_count got %0d exp %0d", err_count2, n); end
    prog_rst_n = 1'b0;
    #1;
    checks++; if (err_count2 !== 8'd0) begin errors++; $display("[TB] FAIL sat_rst_count got %0d exp 0", err_count2); end
    checks++; if (busy2 !== 1'b0) begin errors++; $display("[TB] FAIL sat_rst_busy got %b exp 0", busy2); end
    checks++; if (shift_en2 !== 1'b0) begin errors++; $display("[TB] FAIL sat_rst_shift_en got %b exp 0", shift_en2); end
    @(negedge prog_clk); prog_rst_n = 1'b1;
  endtask

  // Scenario sequence
  initial begin
    test_reset();
    test_load();
    test_stall();
    test_verify_ok();
    test_verify_bad();
    test_abort();
    test_start_while_busy();
    test_reset_mid_pass();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
